// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: load imem/dmem from a stream, reset and run the cpu for a
// programmed number of cycles, then stream a window of dmem back out.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     command pulse (taken in IDLE or DONE)
//   imem_len, dmem_len        words to load into each memory
//   run_cycles                cycles to hold cpu_enable high
//   dump_len                  dmem words to read back from word 0
//   s_valid/s_data/s_ready    load stream
//   m_valid/m_data/m_ready    dump stream
//   cpu_enable, cpu_arst_n    cpu run enable and reset
//   *_ext                     imem external port (write only)
//   *_ext_2, rdata_ext_2      dmem external port
//   busy, done, cycle_count   status
module cpu_run_ctrl #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int CYC_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       imem_len,
    input  logic [15:0]       dmem_len,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic [15:0]       dump_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              cpu_enable,
    output logic              cpu_arst_n,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              busy,
    output logic              done,
    output logic [CYC_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_CLR,
        S_RUN, S_DUMP_RD, S_DUMP_CAP, S_DONE
    } state_t;

    localparam logic [15:0] IMAX = 16'(IMEM_DEPTH);
    localparam logic [15:0] DMAX = 16'(DMEM_DEPTH);
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_ilen;
    logic [15:0]         r_dlen;
    logic [15:0]         r_dump_len;
    logic [CYC_W-1:0]    r_runlen;
    logic [15:0]         r_idx;
    logic                r_clr;
    logic [CYC_W-1:0]    r_cyc;
    logic                r_mvalid;
    logic [DATA_W-1:0]   r_mdata;
    logic                r_wen_i;
    logic [31:0]         r_waddr_i;
    logic [DATA_W-1:0]   r_wdata_i;
    logic                r_wen_d;
    logic [31:0]         r_waddr_d;
    logic [DATA_W-1:0]   r_wdata_d;

    logic                w_sready;
    logic                w_hs;
    logic [15:0]         w_idx_inc;
    logic [31:0]         w_idx_addr;
    logic                w_take;
    logic                w_live;

    assign w_live     = !rst;
    assign w_idx_inc  = r_idx + 16'd1;
    assign w_idx_addr = {14'd0, r_idx, 2'b00};
    assign w_sready   = (r_state == S_LOAD_I && r_ilen != 16'd0) ||
                        (r_state == S_LOAD_D && r_dlen != 16'd0);
    assign w_hs       = w_sready && s_valid;
    assign w_take     = start && (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next = S_LOAD_I;
            end
            S_LOAD_I: begin
                if (r_ilen == 16'd0 || (w_hs && w_idx_inc == r_ilen))
                    w_next = S_LOAD_D;
            end
            S_LOAD_D: begin
                if (r_dlen == 16'd0 || (w_hs && w_idx_inc == r_dlen))
                    w_next = S_CLR;
            end
            S_CLR: begin
                if (r_clr) begin
                    if (r_runlen != '0)
                        w_next = S_RUN;
                    else if (r_dump_len != 16'd0)
                        w_next = S_DUMP_RD;
                    else
                        w_next = S_DONE;
                end
            end
            S_RUN: begin
                if (r_cyc + CYC_ONE == r_runlen)
                    w_next = (r_dump_len != 16'd0) ? S_DUMP_RD : S_DONE;
            end
            S_DUMP_RD: w_next = S_DUMP_CAP;
            S_DUMP_CAP: begin
                if (r_mvalid && m_ready)
                    w_next = (w_idx_inc == r_dump_len) ? S_DONE : S_DUMP_RD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ilen     <= '0;
            r_dlen     <= '0;
            r_dump_len <= '0;
            r_runlen   <= '0;
            r_idx      <= '0;
            r_clr      <= 1'b0;
            r_cyc      <= '0;
            r_mvalid   <= 1'b0;
            r_mdata    <= '0;
            r_wen_i    <= 1'b0;
            r_waddr_i  <= '0;
            r_wdata_i  <= '0;
            r_wen_d    <= 1'b0;
            r_waddr_d  <= '0;
            r_wdata_d  <= '0;
        end else begin
            r_state   <= w_next;
            // Write pulses last one cycle; idle ports read back as zero.
            r_wen_i   <= 1'b0;
            r_waddr_i <= '0;
            r_wdata_i <= '0;
            r_wen_d   <= 1'b0;
            r_waddr_d <= '0;
            r_wdata_d <= '0;
            if (w_take) begin
                r_ilen     <= (imem_len > IMAX) ? IMAX : imem_len;
                r_dlen     <= (dmem_len > DMAX) ? DMAX : dmem_len;
                r_dump_len <= (dump_len > DMAX) ? DMAX : dump_len;
                r_runlen   <= run_cycles;
                r_idx      <= '0;
                r_clr      <= 1'b0;
                r_cyc      <= '0;
                r_mvalid   <= 1'b0;
            end
            case (r_state)
                S_LOAD_I: if (w_hs) begin
                    r_wen_i   <= 1'b1;
                    r_waddr_i <= w_idx_addr;
                    r_wdata_i <= s_data;
                    r_idx     <= (w_idx_inc == r_ilen) ? 16'd0 : w_idx_inc;
                end
                S_LOAD_D: if (w_hs) begin
                    r_wen_d   <= 1'b1;
                    r_waddr_d <= w_idx_addr;
                    r_wdata_d <= s_data;
                    r_idx     <= (w_idx_inc == r_dlen) ? 16'd0 : w_idx_inc;
                end
                S_CLR: r_clr <= ~r_clr;
                S_RUN: if (r_cyc != {CYC_W{1'b1}}) r_cyc <= r_cyc + CYC_ONE;
                S_DUMP_CAP: begin
                    // First CAP cycle captures read data; then hold for m_ready.
                    if (!r_mvalid) begin
                        r_mdata  <= rdata_ext_2;
                        r_mvalid <= 1'b1;
                    end else if (m_ready) begin
                        r_mvalid <= 1'b0;
                        r_idx    <= w_idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every strobe is masked by rst so an abort takes effect in the rst cycle.
    assign s_ready     = w_live && w_sready;
    assign m_valid     = w_live && r_mvalid;
    assign m_data      = r_mdata;
    assign cpu_enable  = w_live && r_state == S_RUN;
    assign cpu_arst_n  = w_live && r_state != S_CLR;
    assign addr_ext    = w_live ? r_waddr_i : '0;
    assign wen_ext     = w_live && r_wen_i;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = w_live ? r_wdata_i : '0;
    assign wen_ext_2   = w_live && r_wen_d;
    assign ren_ext_2   = w_live && r_state == S_DUMP_RD;
    assign wdata_ext_2 = w_live ? r_wdata_d : '0;
    assign addr_ext_2  = !w_live                 ? 32'd0 :
                         r_wen_d                 ? r_waddr_d :
                         (r_state == S_DUMP_RD)  ? w_idx_addr : 32'd0;
    assign busy        = w_live && r_state != S_IDLE && r_state != S_DONE;
    assign done        = w_live && r_state == S_DONE;
    assign cycle_count = r_cyc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: table-driven command checks plus hand sequences for
// dump backpressure and reset during RUN.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] imem_len = '0;
    logic [15:0] dmem_len = '0;
    logic [31:0] run_cycles = '0;
    logic [15:0] dump_len = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b1;
    logic        cpu_enable, cpu_arst_n;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] rdata_ext_2 = '0;
    logic        busy, done;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    cpu_run_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len),
        .run_cycles(run_cycles), .dump_len(dump_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .cpu_enable(cpu_enable), .cpu_arst_n(cpu_arst_n),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    int n_chk = 0;
    int n_err = 0;
    int cur_row = 0;

    function automatic logic [31:0] iword(int k);
        case (k)
            0: return 32'h2001_0005;
            1: return 32'h2002_0007;
            2: return 32'h0022_1820;
            default: return 32'h1000_0000 + 32'(k);
        endcase
    endfunction

    function automatic logic [31:0] dword(int k);
        return 32'hD000_0000 + 32'(cur_row << 16) + 32'(k * 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory models driven only by the DUT's ports.
    logic [31:0] imem_m [512];
    logic [31:0] dmem_m [1024];
    logic [31:0] gold [1024];
    initial begin
        for (int i = 0; i < 512; i++) imem_m[i] = '0;
        for (int i = 0; i < 1024; i++) begin
            dmem_m[i] = '0;
            gold[i] = '0;
        end
    end
    always @(posedge clk) begin
        if (wen_ext) imem_m[addr_ext[10:2]] <= wdata_ext;
        if (wen_ext_2) dmem_m[addr_ext_2[11:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem_m[addr_ext_2[11:2]];
    end

    // Activity monitor.
    int n_iw, n_dw, n_rd, n_sr, n_en, n_clr, n_busy, n_hs;
    int bad_i, bad_d, stab_bad;
    logic [31:0] last_iaddr;
    logic [31:0] dq [$];
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (wen_ext) begin
                if (addr_ext != 32'(n_iw * 4) || wdata_ext != iword(n_iw))
                    bad_i++;
                last_iaddr = addr_ext;
                n_iw++;
            end
            if (wen_ext_2) begin
                if (addr_ext_2 != 32'(n_dw * 4) || wdata_ext_2 != dword(n_dw))
                    bad_d++;
                n_dw++;
            end
            if (ren_ext_2) begin
                if (addr_ext_2 != 32'(n_rd * 4)) bad_d++;
                n_rd++;
            end
            if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2)) bad_i++;
            if (s_ready) n_sr++;
            if (cpu_enable) n_en++;
            if (!cpu_arst_n) n_clr++;
            if (busy) n_busy++;
            if (s_valid && s_ready) n_hs++;
            if (pv && !pr && (!m_valid || m_data != pd)) stab_bad++;
            if (m_valid && m_ready) dq.push_back(m_data);
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
        end
    end

    // m_ready stall on dump word 1 when enabled.
    logic hold_en = 1'b0;
    int held = 0;
    always @(negedge clk) begin
        if (hold_en && m_valid && dq.size() == 1 && held < 5) begin
            m_ready = 1'b0;
            held++;
        end else begin
            m_ready = 1'b1;
        end
    end

    typedef struct {
        int il, dl, rc, du;
        bit gaps, poke;
        int e_iw, e_dw, e_sr, e_en, e_busy, e_last;
    } vec_t;

    task automatic clear_mon();
        n_iw = 0; n_dw = 0; n_rd = 0; n_sr = 0; n_en = 0;
        n_clr = 0; n_busy = 0; n_hs = 0;
        bad_i = 0; bad_d = 0; stab_bad = 0;
        last_iaddr = '0;
        dq.delete();
    endtask

    task automatic launch(input vec_t v, input int row);
        int ilc, dlc;
        @(negedge clk);
        clear_mon();
        cur_row = row;
        ilc = (v.il > 512) ? 512 : v.il;
        dlc = (v.dl > 1024) ? 1024 : v.dl;
        for (int k = 0; k < dlc; k++) gold[k] = dword(k);
        imem_len = 16'(v.il);
        dmem_len = 16'(v.dl);
        run_cycles = 32'(v.rc);
        dump_len = 16'(v.du);
        s_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input int row, input string nm);
        int cyc, ilc;
        ilc = (v.il > 512) ? 512 : v.il;
        launch(v, row);
        cyc = 0;
        while (!done && cyc < 6000) begin
            s_valid = v.gaps ? (cyc % 3 != 2) : 1'b1;
            s_data = (n_hs < ilc) ? iword(n_hs) : dword(n_hs - ilc);
            start = v.poke && (cyc % 50 == 10);
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        start = 1'b0;
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " imem writes"}, n_iw, v.e_iw);
        chk({nm, " dmem writes"}, n_dw, v.e_dw);
        chk({nm, " write/rd errs"}, bad_i + bad_d, 0);
        chk({nm, " last imem addr"}, last_iaddr, v.e_last);
        chk({nm, " enable cycles"}, n_en, v.e_en);
        chk({nm, " cycle_count"}, cycle_count, v.e_en);
        chk({nm, " cpu reset cycles"}, n_clr, 2);
        chk({nm, " dump reads"}, n_rd, v.du);
        chk({nm, " dump words"}, dq.size(), v.du);
        chk({nm, " m stable"}, stab_bad, 0);
        for (int k = 0; k < dq.size() && k < v.du; k++)
            chk($sformatf("%s dump[%0d]", nm, k), dq[k], gold[k]);
        if (v.e_sr >= 0) chk({nm, " s_ready cycles"}, n_sr, v.e_sr);
        if (v.e_busy >= 0) chk({nm, " busy cycles"}, n_busy, v.e_busy);
    endtask

    vec_t tbl [6];
    vec_t hv;

    initial begin
        int cyc;
        //          il    dl rc  du gaps poke iw  dw sr   en busy last
        tbl[0] = '{3,    0, 0,  0, 0, 0,  3,  0, 3,   0, 6,   8};
        tbl[1] = '{0,    4, 10, 4, 1, 0,  0,  4, -1,  10, -1, 0};
        tbl[2] = '{2000, 0, 0,  0, 0, 1,  512, 0, 512, 0, 515, 32'h7FC};
        tbl[3] = '{0,    0, 0,  0, 0, 0,  0,  0, 0,   0, 4,   0};
        tbl[4] = '{5,    2, 3,  2, 0, 0,  5,  2, 7,   3, 18,  16};
        tbl[5] = '{1,    1, 0,  3, 0, 0,  1,  1, 2,   0, 13,  0};

        clear_mon();
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset arst_n", 32'(cpu_arst_n), 0);
        chk("reset s_ready", 32'(s_ready), 0);
        chk("reset cycle_count", cycle_count, 0);
        chk("reset m_data", m_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle arst_n", 32'(cpu_arst_n), 1);
        chk("idle m_valid", 32'(m_valid), 0);

        for (int r = 0; r < 6; r++)
            run_cmd(tbl[r], r, $sformatf("row%0d", r));

        // Dump backpressure: stall word 1 for 5 cycles.
        hv = '{0, 3, 0, 3, 0, 0, 0, 3, 3, 0, 20, 0};
        hold_en = 1'b1;
        held = 0;
        run_cmd(hv, 6, "stall");
        hold_en = 1'b0;
        chk("stall cycles", held, 5);

        // Reset after 4 cpu_enable cycles.
        hv = '{0, 0, 10, 0, 0, 0, 0, 0, 0, 10, -1, 0};
        launch(hv, 7);
        cyc = 0;
        while (n_en < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst reach run", n_en, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst enable", 32'(cpu_enable), 0);
        chk("rst arst_n", 32'(cpu_arst_n), 0);
        chk("rst wen", 32'(wen_ext | wen_ext_2), 0);
        chk("rst cycle_count", cycle_count, 0);
        chk("rst done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst arst_n", 32'(cpu_arst_n), 1);
        chk("post rst busy", 32'(busy), 0);
        run_cmd(tbl[4], 4, "after rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
